// File: rtl/vote_pkg.sv
// Shared constants, state encoding and status-byte packing for the vote result read-out path.
package vote_pkg;

    localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_LEN      = 7;
    localparam int unsigned NUM_CANDIDATES = 4;
    localparam int unsigned TIE_BIT        = 7;
    localparam int unsigned WINNER_MSB     = 2;
    localparam int unsigned WINNER_LSB     = 0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SEND
    } state_e;

    function automatic logic [7:0] status_byte(input logic tie, input logic [2:0] winner);
        logic [7:0] s;
        s = 8'h00;
        s[TIE_BIT] = tie;
        s[WINNER_MSB:WINNER_LSB] = winner;
        return s;
    endfunction

endpackage

// File: rtl/vote_winner_scan.sv
// Sequential max/winner/tie search over the snapshot, one candidate per step.
module vote_winner_scan
    import vote_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  step,
    input  logic [1:0]                            scan_index,
    input  logic [NUM_CANDIDATES*COUNT_WIDTH-1:0] snapshot,
    output logic [2:0]                            next_winner,
    output logic                                  next_tie
);

    logic [COUNT_WIDTH-1:0] cur_count;
    logic [COUNT_WIDTH-1:0] max_q, max_d;
    logic [2:0]             winner_q;
    logic                   tie_q;

    assign cur_count = snapshot[32'(scan_index) * COUNT_WIDTH +: COUNT_WIDTH];

    // Strictly greater replaces the leader, so ties keep the lowest index.
    always_comb begin
        max_d       = max_q;
        next_winner = winner_q;
        next_tie    = tie_q;
        if (cur_count > max_q) begin
            max_d       = cur_count;
            next_winner = {1'b0, scan_index} + 3'd1;
            next_tie    = 1'b0;
        end else if (cur_count == max_q && max_q != '0) begin
            next_tie = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            max_q    <= '0;
            winner_q <= 3'd0;
            tie_q    <= 1'b0;
        end else if (step) begin
            max_q    <= max_d;
            winner_q <= next_winner;
            tie_q    <= next_tie;
        end
    end

endmodule

// File: rtl/vote_result_reporter.sv
// Snapshots the tallies on start, scans for winner/tie, then streams a 7-byte result frame.
module vote_result_reporter
    import vote_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] candidate1_vote_count,
    input  logic [COUNT_WIDTH-1:0] candidate2_vote_count,
    input  logic [COUNT_WIDTH-1:0] candidate3_vote_count,
    input  logic [COUNT_WIDTH-1:0] candidate4_vote_count,
    output logic                   busy,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   done,
    output logic [2:0]             winner_id,
    output logic                   tie,
    output logic                   result_valid
);

    localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);

    state_e                                state_q, state_d;
    logic [NUM_CANDIDATES*COUNT_WIDTH-1:0] snapshot_q;
    logic [1:0]                            scan_idx_q;
    logic [2:0]                            byte_idx_q;
    logic [2:0]                            winner_id_q;
    logic                                  tie_q;
    logic                                  result_valid_q;
    logic                                  done_q;
    logic                                  accept;
    logic                                  last_xfer;
    logic [2:0]                            scan_winner;
    logic                                  scan_tie;
    logic [7:0]                            status;
    logic [7:0]                            checksum;
    logic [7:0]                            frame_byte;

    assign accept    = (state_q == IDLE) && start;
    assign last_xfer = (state_q == SEND) && out_ready && (byte_idx_q == LAST_BYTE);

    vote_winner_scan #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_scan (
        .clock       (clock),
        .reset       (reset),
        .clear       (accept),
        .step        (state_q == SCAN),
        .scan_index  (scan_idx_q),
        .snapshot    (snapshot_q),
        .next_winner (scan_winner),
        .next_tie    (scan_tie)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (scan_idx_q == 2'd3) state_d = SEND;
            SEND:    if (last_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            snapshot_q     <= '0;
            scan_idx_q     <= 2'd0;
            byte_idx_q     <= 3'd0;
            winner_id_q    <= 3'd0;
            tie_q          <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_xfer;
            if (accept) begin
                snapshot_q     <= {candidate4_vote_count, candidate3_vote_count,
                                   candidate2_vote_count, candidate1_vote_count};
                scan_idx_q     <= 2'd0;
                winner_id_q    <= 3'd0;
                tie_q          <= 1'b0;
                result_valid_q <= 1'b0;
            end
            if (state_q == SCAN) begin
                scan_idx_q <= scan_idx_q + 2'd1;
                if (scan_idx_q == 2'd3) begin
                    winner_id_q    <= scan_winner;
                    tie_q          <= scan_tie;
                    result_valid_q <= 1'b1;
                    byte_idx_q     <= 3'd0;
                end
            end
            if (state_q == SEND && out_ready) begin
                byte_idx_q <= last_xfer ? 3'd0 : byte_idx_q + 3'd1;
            end
        end
    end

    // Byte selection depends only on registered state, so data holds during stalls.
    always_comb begin
        status   = status_byte(tie_q, winner_id_q);
        checksum = HEADER ^ status;
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            checksum = checksum ^ snapshot_q[i*COUNT_WIDTH +: COUNT_WIDTH];
        end
        frame_byte = 8'h00;
        unique case (byte_idx_q)
            3'd0:    frame_byte = HEADER;
            3'd1:    frame_byte = snapshot_q[0*COUNT_WIDTH +: COUNT_WIDTH];
            3'd2:    frame_byte = snapshot_q[1*COUNT_WIDTH +: COUNT_WIDTH];
            3'd3:    frame_byte = snapshot_q[2*COUNT_WIDTH +: COUNT_WIDTH];
            3'd4:    frame_byte = snapshot_q[3*COUNT_WIDTH +: COUNT_WIDTH];
            3'd5:    frame_byte = status;
            3'd6:    frame_byte = checksum;
            default: frame_byte = 8'h00;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == SEND);
    assign out_data     = out_valid ? frame_byte : 8'h00;
    assign done         = done_q;
    assign winner_id    = winner_id_q;
    assign tie          = tie_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_vote_result_reporter.sv
// Self-checking bench for vote_result_reporter against a frame-level reference model.
module tb_vote_result_reporter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] c1 = 8'h00, c2 = 8'h00, c3 = 8'h00, c4 = 8'h00;
    logic       busy, out_valid, done, tie, result_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] winner_id;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         t0c = 0;
    logic [7:0] rx [7];
    logic [7:0] exp_b [7];
    logic [2:0] exp_win;
    logic       exp_tie;
    int         first_valid, last_xfer, stall_bad;
    bit         timed_out;

    vote_result_reporter dut (
        .clock                 (clock),
        .reset                 (reset),
        .start                 (start),
        .candidate1_vote_count (c1),
        .candidate2_vote_count (c2),
        .candidate3_vote_count (c3),
        .candidate4_vote_count (c4),
        .busy                  (busy),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .done                  (done),
        .winner_id             (winner_id),
        .tie                   (tie),
        .result_valid          (result_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Reference model: winner is the lowest-numbered holder of a nonzero maximum.
    task automatic set_expected(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v [4];
        int mx;
        int nmax;
        v = '{a, b, c, d};
        mx = 0;
        nmax = 0;
        exp_win = 3'd0;
        for (int i = 0; i < 4; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
        for (int i = 0; i < 4; i++) begin
            if (mx != 0 && int'(v[i]) == mx) begin
                nmax++;
                if (exp_win == 3'd0) exp_win = 3'(i + 1);
            end
        end
        exp_tie = (nmax > 1);
        exp_b[0] = 8'hA5;
        for (int i = 0; i < 4; i++) exp_b[i+1] = v[i];
        exp_b[5] = {exp_tie, 4'b0000, exp_win};
        exp_b[6] = 8'h00;
        for (int i = 0; i < 6; i++) exp_b[6] = exp_b[6] ^ exp_b[i];
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        c1 = a; c2 = b; c3 = c; c4 = d;
        set_expected(a, b, c, d);
        start = 1'b1;
        step();
        start = 1'b0;
        t0c = cyc;
    endtask

    // Observes one frame; mode 0 ready high, 1 toggling, 2 random. Pulses start at byte start_at.
    task automatic collect(input int mode, input int start_at);
        int n;
        int k;
        bit prev_stall;
        logic [7:0] prev_data;
        n = 0; k = 0; prev_stall = 0; prev_data = 8'h00;
        first_valid = -1; last_xfer = -1; stall_bad = 0; timed_out = 0;
        while (n < 7 && !timed_out) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = (k % 2 == 0);
            else out_ready = 1'($urandom_range(0, 1));
            start = (n == start_at);
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stall_bad++;
            if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
            if (out_valid === 1'b1 && out_ready) begin
                rx[n] = out_data;
                n++;
                last_xfer = cyc;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_data = out_data;
            step();
            k++;
            if (k > 400) timed_out = 1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        step(); step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if ({winner_id, tie, result_valid} !== 5'b0) begin
            bad++; $display("FAIL reset_result got=%b want=00000", {winner_id, tie, result_valid});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_tie_directed();
        launch(8'h03, 8'h07, 8'h07, 8'h01);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tie_busy got=%b want=1", busy); end
        collect(0, -1);
        total++; if (timed_out) begin bad++; $display("FAIL tie_timeout got=1 want=0"); end
        for (int i = 0; i < 7; i++) begin
            total++; if (rx[i] !== exp_b[i]) begin bad++; $display("FAIL tie_byte%0d got=%h want=%h", i, rx[i], exp_b[i]); end
        end
        total++; if (rx[5] !== 8'h82 || rx[6] !== 8'h25) begin
            bad++; $display("FAIL tie_literal got=%h%h want=8225", rx[5], rx[6]);
        end
        total++; if (first_valid != t0c + 4) begin bad++; $display("FAIL tie_first got=%0d want=%0d", first_valid - t0c, 4); end
        total++; if (last_xfer != t0c + 10) begin bad++; $display("FAIL tie_last got=%0d want=%0d", last_xfer - t0c, 10); end
        total++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL tie_done got=%b%b%b want=100", done, busy, out_valid);
        end
        total++; if (winner_id !== 3'd2 || tie !== 1'b1 || result_valid !== 1'b1) begin
            bad++; $display("FAIL tie_result got=%0d/%b/%b want=2/1/1", winner_id, tie, result_valid);
        end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL tie_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_all_zero();
        launch(8'h00, 8'h00, 8'h00, 8'h00);
        collect(0, -1);
        total++; if (timed_out) begin bad++; $display("FAIL zero_timeout got=1 want=0"); end
        for (int i = 0; i < 7; i++) begin
            total++; if (rx[i] !== exp_b[i]) begin bad++; $display("FAIL zero_byte%0d got=%h want=%h", i, rx[i], exp_b[i]); end
        end
        total++; if (winner_id !== 3'd0 || tie !== 1'b0 || result_valid !== 1'b1) begin
            bad++; $display("FAIL zero_result got=%0d/%b/%b want=0/0/1", winner_id, tie, result_valid);
        end
        step();
    endtask

    task automatic test_backpressure();
        launch(8'h0A, 8'h14, 8'h1E, 8'h28);
        collect(1, -1);
        total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=1 want=0"); end
        for (int i = 0; i < 7; i++) begin
            total++; if (rx[i] !== exp_b[i]) begin bad++; $display("FAIL bp_byte%0d got=%h want=%h", i, rx[i], exp_b[i]); end
        end
        total++; if (rx[5] !== 8'h04 || rx[6] !== 8'h89) begin
            bad++; $display("FAIL bp_literal got=%h%h want=0489", rx[5], rx[6]);
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d want=0", stall_bad); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b want=1", done); end
        step();
    endtask

    task automatic test_snapshot();
        launch(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        c1 = 8'h00; c2 = 8'h00; c3 = 8'h00; c4 = 8'h00;
        collect(0, -1);
        for (int i = 0; i < 7; i++) begin
            total++; if (rx[i] !== exp_b[i]) begin bad++; $display("FAIL snap_byte%0d got=%h want=%h", i, rx[i], exp_b[i]); end
        end
        total++; if (rx[5] !== 8'h81 || rx[6] !== 8'h24) begin
            bad++; $display("FAIL snap_literal got=%h%h want=8124", rx[5], rx[6]);
        end
        step();
    endtask

    task automatic test_back_to_back();
        launch(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        collect(0, 3);
        total++; if (timed_out) begin bad++; $display("FAIL b2b_timeout got=1 want=0"); end
        for (int i = 0; i < 7; i++) begin
            total++; if (rx[i] !== exp_b[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, rx[i], exp_b[i]); end
        end
        total++; if (last_xfer != t0c + 10) begin bad++; $display("FAIL b2b_last got=%0d want=10", last_xfer - t0c); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", done); end
        launch(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
        total++; if (busy !== 1'b1 || result_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_restart got=%b%b want=10", busy, result_valid);
        end
        collect(0, -1);
        total++; if (first_valid != t0c + 4) begin bad++; $display("FAIL b2b_first got=%0d want=4", first_valid - t0c); end
        for (int i = 0; i < 7; i++) begin
            total++; if (rx[i] !== exp_b[i]) begin bad++; $display("FAIL b2b2_byte%0d got=%h want=%h", i, rx[i], exp_b[i]); end
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        launch(8'h11, 8'h22, 8'h33, 8'h44);
        out_ready = 1'b1;
        repeat (7) step();
        total++; if (out_valid !== 1'b1 || out_data !== exp_b[3]) begin
            bad++; $display("FAIL rst_byte3 got=%b/%h want=1/%h", out_valid, out_data, exp_b[3]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if ({out_valid, busy, done, result_valid, tie} !== 5'b0 || winner_id !== 3'd0) begin
            bad++; $display("FAIL rst_abort got=%b%b%b%b%b/%0d want=00000/0", out_valid, busy, done, result_valid, tie, winner_id);
        end
        begin
            bit saw_done;
            saw_done = 0;
            repeat (10) begin step(); if (done === 1'b1 || busy === 1'b1) saw_done = 1; end
            total++; if (saw_done) begin bad++; $display("FAIL rst_no_done got=1 want=0"); end
        end
        launch(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        collect(0, -1);
        total++; if (timed_out) begin bad++; $display("FAIL rst_timeout got=1 want=0"); end
        for (int i = 0; i < 7; i++) begin
            total++; if (rx[i] !== exp_b[i]) begin bad++; $display("FAIL rst_byte%0d got=%h want=%h", i, rx[i], exp_b[i]); end
        end
        step();
    endtask

    task automatic test_random();
        logic [7:0] v [4];
        for (int it = 0; it < 24; it++) begin
            for (int j = 0; j < 4; j++) begin
                v[j] = (it % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            end
            launch(v[0], v[1], v[2], v[3]);
            collect(2, -1);
            total++; if (timed_out) begin bad++; $display("FAIL rand%0d_timeout got=1 want=0", it); end
            for (int i = 0; i < 7; i++) begin
                total++; if (rx[i] !== exp_b[i]) begin
                    bad++; $display("FAIL rand%0d_byte%0d got=%h want=%h", it, i, rx[i], exp_b[i]);
                end
            end
            total++; if (stall_bad != 0) begin bad++; $display("FAIL rand%0d_stall got=%0d want=0", it, stall_bad); end
            total++; if (done !== 1'b1 || winner_id !== exp_win || tie !== exp_tie) begin
                bad++; $display("FAIL rand%0d_result got=%b/%0d/%b want=1/%0d/%b", it, done, winner_id, tie, exp_win, exp_tie);
            end
            out_ready = 1'b0;
            step();
            total++; if (done !== 1'b0 || result_valid !== 1'b1) begin
                bad++; $display("FAIL rand%0d_after got=%b%b want=01", it, done, result_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie_directed();
        test_all_zero();
        test_backpressure();
        test_snapshot();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vote_result_reporter.md
# vote_result_reporter

Read-out end of the vote-counting path. On a `start` pulse it snapshots the four 8-bit candidate tallies, sequentially determines the winner and whether the lead is tied, then streams a 7-byte result frame over a valid/ready byte interface to the display or UART side. It sits directly downstream of the vote logger, which keeps counting undisturbed during readout.

## Interface
- `HEADER`, default 8'hA5: frame start byte.
- `COUNT_WIDTH`, default 8: tally width. The frame format requires 8.
- `clock`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  readout request. Sampled only in IDLE.
- `candidate1_vote_count` … `candidate4_vote_count`  in  8 each  live tallies.
- `busy`  out  1  high from the cycle after `start` is accepted until the last byte transfers.
- `out_data`  out  8  frame byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the byte.
- `done`  out  1  one-cycle pulse after the final byte transfers.
- `winner_id`  out  3  winning candidate number, 1..4. 0 when all tallies are 0.
- `tie`  out  1  at least two candidates share a nonzero maximum.
- `result_valid`  out  1  `winner_id` and `tie` reflect the latest completed scan.

## Operation
- **Reset values:** all outputs are 0 and the state is IDLE.
- **FSM states:** IDLE → SCAN → SEND → IDLE.
- **IDLE:**
  - When `start` is 1 at an edge, latch all four counts into a snapshot, clear the scan registers and go to SCAN.
  - Later changes to the inputs do not affect the frame.
- **SCAN:** 4 cycles, one candidate per cycle in order 1, 2, 3, 4. For each candidate:
  - count > max: set max = count, winner = index, tie = 0.
  - count == max and max ≠ 0: set tie = 1. The winner stays at the lowest index.
  - At the end of the 4th cycle, update `winner_id` and `tie` and set `result_valid` = 1. These hold until the next accepted `start`.
  - `result_valid` clears when `start` is accepted.
- **SEND:** byte index 0..6.
  - Byte 0: `HEADER`.
  - Bytes 1–4: snapshot counts for candidates 1 to 4.
  - Byte 5: status = {tie, 4'b0, winner_id}.
  - Byte 6: checksum = XOR of bytes 0–5.
- **Handshake:**
  - A byte transfers on an edge where `out_valid` and `out_ready` are both 1.
  - While `out_valid` is 1 and `out_ready` is 0, `out_data` and `out_valid` hold stable.
  - `out_valid` never drops without a transfer, except on reset.
  - `out_ready` is a don't-care outside SEND.
- `start` is ignored while `busy` is 1. It is not queued.
- **Reset mid-scan or mid-frame:** aborts immediately. All outputs are 0 in the next cycle and no `done` pulse is produced.

## Timing
- Edge t0: `start` is accepted. `busy` = 1 from cycle t0+1.
- SCAN occupies cycles t0+1 to t0+4. `result_valid` = 1 from cycle t0+5.
- `out_valid` = 1 from cycle t0+5, carrying byte 0.
- With `out_ready` held high: bytes transfer in cycles t0+5 to t0+11, one per cycle with no bubbles.
- After the final transfer edge, in the next cycle:
  - `done` = 1.
  - `busy` = 0 and `out_valid` = 0.
  - The state is IDLE, so a `start` in the `done` cycle is accepted.
- **Back-pressure:** each cycle with `out_ready` = 0 during SEND adds one cycle. There is no timeout.

## Structure
- Shared package `vote_pkg` holds:
  - `HEADER_DEFAULT` = 8'hA5.
  - `FRAME_LEN` = 7.
  - Status bit positions: `TIE_BIT` = 7, winner field [2:0].
  - State enum {IDLE, SCAN, SEND}.
  - `NUM_CANDIDATES` = 4.
- One sub-module, `vote_winner_scan`, is natural. It takes the snapshot and a scan index and produces max, winner and tie. The top-level handles the FSM, snapshot and byte mux.

## Test plan
- Counts 3, 7, 7, 1, `start` pulse, `out_ready` = 1 → frame A5 03 07 07 01 82 25 in cycles t0+5 to t0+11, `winner_id` = 2, `tie` = 1, `done` high at t0+12.
- All counts 0 → frame A5 00 00 00 00 00 A5, `winner_id` = 0, `tie` = 0.
- Counts 0A, 14, 1E, 28 with `out_ready` toggling 1, 0, 1, 0… → frame A5 0A 14 1E 28 04 89, `out_data` stable during stalls, `done` after 7 transfers.
- Counts FF×4 → status 81, checksum 24. Inputs changed to 00 after `start` → frame still carries FF.
- `start` pulsed again mid-SEND → ignored, frame unchanged. `start` in the `done` cycle → new frame with `out_valid` at +5.
- `reset` asserted during byte 3 → next cycle `out_valid`, `busy`, `done`, `result_valid`, `winner_id` and `tie` are all 0, and a fresh `start` produces a complete frame.
